alu_issue_stage: RTL and testbench

- Decode/issue pipeline stage that drives the 32-bit ALU.
- Accepts one RV32I integer instruction per cycle, with register-file read data already attached.
- Translates the instruction into the ALU's 4-bit opcode plus two operands, registers them, and presents them to the execute stage over a valid/ready handshake.
- Has a 2-entry skid buffer so in_ready is a registered signal, and a synchronous flush for branch redirects.

---
 rtl/alu_issue_if.sv | 38 +++
 rtl/alu_issue_stage.sv | 223 ++++++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_if.sv
// alu_issue_if: handshake bundle between the decode/issue stage, its
// upstream instruction source and the downstream ALU execute stage.
//
// Handshake rule on both sides: a transfer happens on a rising clk edge
// where valid && ready are both high. A producer holds valid and its
// payload steady until that edge; a consumer may change ready freely.
// Neither side waits for the other's signal before raising its own.
interface alu_issue_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_rs1_data;
    logic [XLEN-1:0] in_rs2_data;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_operand1;
    logic [XLEN-1:0] out_operand2;
    logic [3:0]      out_alu_op;
    logic [4:0]      out_rd;
    logic            out_illegal;

    // Issue stage view
    modport slave (
        input  in_valid, in_instr, in_rs1_data, in_rs2_data, out_ready,
        output in_ready, out_valid, out_operand1, out_operand2,
               out_alu_op, out_rd, out_illegal
    );

    // Environment view (upstream source plus execute stage)
    modport master (
        output in_valid, in_instr, in_rs1_data, in_rs2_data, out_ready,
        input  in_ready, out_valid, out_operand1, out_operand2,
               out_alu_op, out_rd, out_illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes one RV32I integer ALU instruction per cycle into
// an ALU opcode plus two operands and issues it through a 2-entry
// (main + skid) buffer, so in_ready comes straight from a flop.
//
// Optional build macro ALU_STRENGTH_REDUCE_EN: when defined, ADDI +1 / ADDI -1
// / XORI -1 issue INC / DEC / NOT with operand2 = 0. When undefined they are
// ordinary ADD / XOR with the sign-extended immediate.
//
// Buffer occupancy is visible as out_valid (main full) and !in_ready
// (skid full); there is no other hidden state.
module alu_issue_stage #(
    parameter int         XLEN       = 32,
    parameter logic [3:0] ILLEGAL_OP = 4'b1111
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    alu_issue_if.slave  bus
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b0111;
`ifdef ALU_STRENGTH_REDUCE_EN
    localparam logic [3:0] OP_NOT = 4'b0101;
    localparam logic [3:0] OP_INC = 4'b1000;
    localparam logic [3:0] OP_DEC = 4'b1001;
`endif

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    typedef struct packed {
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [3:0]      alu_op;
        logic [4:0]      rd;
        logic            illegal;
    } entry_t;

    // Instruction fields
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [11:0]     imm12;
    logic [XLEN-1:0] imm_sext;
    logic [XLEN-1:0] shamt_imm;
    logic [XLEN-1:0] shamt_reg;

    assign opcode    = bus.in_instr[6:0];
    assign funct3    = bus.in_instr[14:12];
    assign funct7    = bus.in_instr[31:25];
    assign imm12     = bus.in_instr[31:20];
    assign imm_sext  = {{(XLEN-12){imm12[11]}}, imm12};
    assign shamt_imm = {{(XLEN-5){1'b0}}, bus.in_instr[24:20]};
    assign shamt_reg = {{(XLEN-5){1'b0}}, bus.in_rs2_data[4:0]};

    // The rs1/rs2 index fields are resolved by the register file upstream.
    logic unused_reg_idx;
    assign unused_reg_idx = ^bus.in_instr[19:15];

    logic            dec_legal;
    logic [3:0]      dec_op;
    logic [XLEN-1:0] dec_op2;
    entry_t          dec;

    // Decode the incoming instruction into a complete buffer entry
    always_comb begin
        dec_legal = 1'b0;
        dec_op    = OP_ADD;
        dec_op2   = '0;
        case (opcode)
            OPC_OP: begin
                case ({funct7, funct3})
                    {7'b0000000, 3'b000}: begin dec_legal = 1'b1; dec_op = OP_ADD; dec_op2 = bus.in_rs2_data; end
                    {7'b0100000, 3'b000}: begin dec_legal = 1'b1; dec_op = OP_SUB; dec_op2 = bus.in_rs2_data; end
                    {7'b0000000, 3'b111}: begin dec_legal = 1'b1; dec_op = OP_AND; dec_op2 = bus.in_rs2_data; end
                    {7'b0000000, 3'b110}: begin dec_legal = 1'b1; dec_op = OP_OR;  dec_op2 = bus.in_rs2_data; end
                    {7'b0000000, 3'b100}: begin dec_legal = 1'b1; dec_op = OP_XOR; dec_op2 = bus.in_rs2_data; end
                    {7'b0000000, 3'b001}: begin dec_legal = 1'b1; dec_op = OP_SLL; dec_op2 = shamt_reg; end
                    {7'b0000000, 3'b101}: begin dec_legal = 1'b1; dec_op = OP_SRL; dec_op2 = shamt_reg; end
                    default:              dec_legal = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                case (funct3)
                    3'b000: begin
                        dec_legal = 1'b1;
                        dec_op    = OP_ADD;
                        dec_op2   = imm_sext;
`ifdef ALU_STRENGTH_REDUCE_EN
                        if (imm12 == 12'h001) begin
                            dec_op  = OP_INC;
                            dec_op2 = '0;
                        end else if (imm12 == 12'hFFF) begin
                            dec_op  = OP_DEC;
                            dec_op2 = '0;
                        end
`endif
                    end
                    3'b100: begin
                        dec_legal = 1'b1;
                        dec_op    = OP_XOR;
                        dec_op2   = imm_sext;
`ifdef ALU_STRENGTH_REDUCE_EN
                        if (imm12 == 12'hFFF) begin
                            dec_op  = OP_NOT;
                            dec_op2 = '0;
                        end
`endif
                    end
                    3'b110: begin dec_legal = 1'b1; dec_op = OP_OR;  dec_op2 = imm_sext; end
                    3'b111: begin dec_legal = 1'b1; dec_op = OP_AND; dec_op2 = imm_sext; end
                    3'b001: begin
                        dec_legal = (funct7 == 7'b0000000);
                        dec_op    = OP_SLL;
                        dec_op2   = shamt_imm;
                    end
                    3'b101: begin
                        // funct7 = 0100000 here is SRAI, which this ALU lacks
                        dec_legal = (funct7 == 7'b0000000);
                        dec_op    = OP_SRL;
                        dec_op2   = shamt_imm;
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase

        dec.rd = bus.in_instr[11:7];
        if (dec_legal) begin
            dec.op1     = bus.in_rs1_data;
            dec.op2     = dec_op2;
            dec.alu_op  = dec_op;
            dec.illegal = 1'b0;
        end else begin
            // Illegal entries still flow downstream so the trap lands in order
            dec.op1     = '0;
            dec.op2     = '0;
            dec.alu_op  = ILLEGAL_OP;
            dec.illegal = 1'b1;
        end
    end

    // Buffer state
    logic   main_valid;
    logic   skid_full;
    logic   in_ready_q;
    entry_t main_q;
    entry_t skid_q;

    logic   main_valid_nxt;
    logic   skid_full_nxt;
    entry_t main_nxt;
    entry_t skid_nxt;

    logic   accept;
    logic   drain;

    assign accept = bus.in_valid && in_ready_q;
    assign drain  = main_valid && bus.out_ready;

    // Next buffer contents: flush first, then drain/refill, then plain accept
    always_comb begin
        main_valid_nxt = main_valid;
        skid_full_nxt  = skid_full;
        main_nxt       = main_q;
        skid_nxt       = skid_q;
        if (flush) begin
            main_valid_nxt = 1'b0;
            skid_full_nxt  = 1'b0;
        end else if (drain) begin
            if (skid_full) begin
                // in_ready is low whenever skid is full, so no accept here
                main_nxt      = skid_q;
                skid_full_nxt = 1'b0;
            end else if (accept) begin
                main_nxt = dec;
            end else begin
                main_valid_nxt = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid) begin
                main_nxt       = dec;
                main_valid_nxt = 1'b1;
            end else begin
                skid_nxt      = dec;
                skid_full_nxt = 1'b1;
            end
        end
    end

    // Register buffer state; in_ready tracks the next skid occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_full  <= 1'b0;
            in_ready_q <= 1'b1;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            main_valid <= main_valid_nxt;
            skid_full  <= skid_full_nxt;
            in_ready_q <= !skid_full_nxt;
            main_q     <= main_nxt;
            skid_q     <= skid_nxt;
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = main_valid;
    assign bus.out_operand1 = main_q.op1;
    assign bus.out_operand2 = main_q.op2;
    assign bus.out_alu_op   = main_q.alu_op;
    assign bus.out_rd       = main_q.rd;
    assign bus.out_illegal  = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed decode vectors, hand-written backpressure,
// flush and reset sequences, then random traffic against a FIFO model.
module tb_alu_issue_stage;

    localparam int W = 74;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        exp_t        exp;
    } vec_t;

    localparam logic [3:0] A_ADD = 4'h0, A_SUB = 4'h1, A_AND = 4'h2, A_OR = 4'h3;
    localparam logic [3:0] A_XOR = 4'h4, A_NOT = 4'h5, A_SLL = 4'h6, A_SRL = 4'h7;
    localparam logic [3:0] A_INC = 4'h8, A_DEC = 4'h9, A_ILL = 4'hF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] exp_q[$];

    alu_issue_if #(.XLEN(32)) bus();

    alu_issue_stage #(.XLEN(32), .ILLEGAL_OP(4'b1111)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        flush = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // scoreboard helpers
    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t get_act();
        return {bus.out_operand1, bus.out_operand2, bus.out_alu_op, bus.out_rd, bus.out_illegal};
    endfunction

    function automatic exp_t mk_exp(logic [31:0] op1, logic [31:0] op2, logic [3:0] op,
                                    logic [4:0] rd, logic ill);
        exp_t e;
        e.op1 = op1; e.op2 = op2; e.op = op; e.rd = rd; e.ill = ill;
        return e;
    endfunction

    function automatic vec_t mk_vec(string name, logic [31:0] instr, logic [31:0] rs1,
                                    logic [31:0] rs2, exp_t e);
        vec_t v;
        v.name = name; v.instr = instr; v.rs1 = rs1; v.rs2 = rs2; v.exp = e;
        return v;
    endfunction

    function automatic logic [31:0] add_instr(int rd);
        logic [31:0] rd_bits;
        rd_bits = 32'(rd) << 7;
        return 32'h00208033 | rd_bits;
    endfunction

    // Reference decode: classify by format, then look the operation up by funct3
    function automatic exp_t ref_decode(logic [31:0] instr, logic [31:0] rs1, logic [31:0] rs2);
        logic [3:0]  by_f3 [8];
        logic [6:0]  opc;
        logic [6:0]  f7;
        int          f3;
        logic [31:0] imm;
        logic [11:0] raw_imm;
        exp_t        e;
        bit          ok;
        by_f3[0] = A_ADD; by_f3[1] = A_SLL; by_f3[2] = A_ILL; by_f3[3] = A_ILL;
        by_f3[4] = A_XOR; by_f3[5] = A_SRL; by_f3[6] = A_OR;  by_f3[7] = A_AND;
        opc = instr[6:0];
        f7  = instr[31:25];
        f3  = int'(instr[14:12]);
        raw_imm = instr[31:20];
        imm = {{20{raw_imm[11]}}, raw_imm};
        ok  = 1'b0;
        e   = mk_exp(rs1, 32'h0, A_ADD, instr[11:7], 1'b0);
        if (opc == 7'h33) begin
            if (f7 == 7'h00 && by_f3[f3] != A_ILL) begin
                ok = 1'b1;
                e.op = by_f3[f3];
                e.op2 = (f3 == 1 || f3 == 5) ? (rs2 % 32) : rs2;
            end else if (f7 == 7'h20 && f3 == 0) begin
                ok = 1'b1;
                e.op = A_SUB;
                e.op2 = rs2;
            end
        end else if (opc == 7'h13) begin
            if (f3 == 1 || f3 == 5) begin
                ok = (f7 == 7'h00);
                e.op = by_f3[f3];
                e.op2 = {27'd0, instr[24:20]};
            end else if (by_f3[f3] != A_ILL) begin
                ok = 1'b1;
                e.op = by_f3[f3];
                e.op2 = imm;
`ifdef ALU_STRENGTH_REDUCE_EN
                if (f3 == 0 && imm == 32'd1)          begin e.op = A_INC; e.op2 = 0; end
                if (f3 == 0 && imm == 32'hFFFFFFFF)   begin e.op = A_DEC; e.op2 = 0; end
                if (f3 == 4 && imm == 32'hFFFFFFFF)   begin e.op = A_NOT; e.op2 = 0; end
`endif
            end
        end
        if (!ok) e = mk_exp(32'h0, 32'h0, A_ILL, instr[11:7], 1'b1);
        return e;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] r;
        logic [6:0]  f7;
        logic [11:0] imm;
        int          sel;
        int          k;
        r   = $urandom;
        sel = $urandom_range(0, 9);
        if (sel < 4) begin
            k = $urandom_range(0, 3);
            f7 = (k < 2) ? 7'h00 : (k == 2) ? 7'h20 : r[31:25];
            return {f7, r[24:15], r[14:12], r[11:7], 7'b0110011};
        end else if (sel < 8) begin
            k = $urandom_range(0, 5);
            case (k)
                0: imm = 12'h001;
                1: imm = 12'hFFF;
                2: imm = {7'h00, r[24:20]};
                3: imm = {7'h20, r[24:20]};
                default: imm = r[31:20];
            endcase
            return {imm, r[19:15], r[14:12], r[11:7], 7'b0010011};
        end
        return r;
    endfunction

    // driver task: one instruction through an empty stage
    task automatic run_vec(input vec_t v);
        bus.in_valid = 1'b1;
        bus.in_instr = v.instr;
        bus.in_rs1_data = v.rs1;
        bus.in_rs2_data = v.rs2;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check({v.name, "_valid"}, W'(bus.out_valid), W'(1'b1));
        check(v.name, get_act(), v.exp);
        @(negedge clk);
        check({v.name, "_drained"}, W'(bus.out_valid), W'(1'b0));
    endtask

    vec_t vecs[12];
    logic [31:0] seen[$];
    bit accept_now;

    initial begin
        // stimulus table
        vecs[0]  = mk_vec("add",  32'h002081B3, 32'd5, 32'd7, mk_exp(32'd5, 32'd7, A_ADD, 5'd3, 1'b0));
        vecs[1]  = mk_vec("sub",  32'h402081B3, 32'd5, 32'd7, mk_exp(32'd5, 32'd7, A_SUB, 5'd3, 1'b0));
        vecs[2]  = mk_vec("slli", 32'h00309213, 32'd1, 32'd9, mk_exp(32'd1, 32'd3, A_SLL, 5'd4, 1'b0));
        vecs[3]  = mk_vec("and",  32'h0020F1B3, 32'h0000F0F0, 32'h0000FF00,
                          mk_exp(32'h0000F0F0, 32'h0000FF00, A_AND, 5'd3, 1'b0));
        vecs[4]  = mk_vec("srl",  32'h0020D1B3, 32'h80000000, 32'h00000025,
                          mk_exp(32'h80000000, 32'd5, A_SRL, 5'd3, 1'b0));
        vecs[5]  = mk_vec("sra",  32'h4020D1B3, 32'd5, 32'd7, mk_exp(32'd0, 32'd0, A_ILL, 5'd3, 1'b1));
        vecs[6]  = mk_vec("lw",   32'h00002183, 32'd5, 32'd7, mk_exp(32'd0, 32'd0, A_ILL, 5'd3, 1'b1));
        vecs[7]  = mk_vec("slli_bad", 32'h40309213, 32'd1, 32'd0, mk_exp(32'd0, 32'd0, A_ILL, 5'd4, 1'b1));
`ifdef ALU_STRENGTH_REDUCE_EN
        vecs[8]  = mk_vec("addi_m1", 32'hFFF00293, 32'd0, 32'd0, mk_exp(32'd0, 32'd0, A_DEC, 5'd5, 1'b0));
        vecs[9]  = mk_vec("xori_m1", 32'hFFF0C313, 32'h12345678, 32'd0,
                          mk_exp(32'h12345678, 32'd0, A_NOT, 5'd6, 1'b0));
        vecs[10] = mk_vec("addi_p1", 32'h00108293, 32'd10, 32'd0, mk_exp(32'd10, 32'd0, A_INC, 5'd5, 1'b0));
`else
        vecs[8]  = mk_vec("addi_m1", 32'hFFF00293, 32'd0, 32'd0,
                          mk_exp(32'd0, 32'hFFFFFFFF, A_ADD, 5'd5, 1'b0));
        vecs[9]  = mk_vec("xori_m1", 32'hFFF0C313, 32'h12345678, 32'd0,
                          mk_exp(32'h12345678, 32'hFFFFFFFF, A_XOR, 5'd6, 1'b0));
        vecs[10] = mk_vec("addi_p1", 32'h00108293, 32'd10, 32'd0, mk_exp(32'd10, 32'd1, A_ADD, 5'd5, 1'b0));
`endif
        vecs[11] = mk_vec("or",   32'h0020E1B3, 32'h00F0, 32'h0F00, mk_exp(32'h00F0, 32'h0F00, A_OR, 5'd3, 1'b0));

        bus.in_instr = 32'h0;
        bus.in_rs1_data = 32'h0;
        bus.in_rs2_data = 32'h0;
        do_reset();

        // reset state
        check("rst_valid", W'(bus.out_valid), W'(1'b0));
        check("rst_ready", W'(bus.in_ready), W'(1'b1));
        check("rst_fields", get_act(), W'(0));

        foreach (vecs[i]) run_vec(vecs[i]);

        // backpressure: three ADDs while out_ready is low
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_instr = add_instr(1); bus.in_rs1_data = 32'd1; bus.in_rs2_data = 32'd0;
        @(negedge clk);
        check("bp_ready_after1", W'(bus.in_ready), W'(1'b1));
        bus.in_instr = add_instr(2); bus.in_rs1_data = 32'd2;
        @(negedge clk);
        check("bp_ready_after2", W'(bus.in_ready), W'(1'b0));
        bus.in_instr = add_instr(3); bus.in_rs1_data = 32'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold_ready", W'(bus.in_ready), W'(1'b0));
            check("bp_hold_data", get_act(), mk_exp(32'd1, 32'd0, A_ADD, 5'd1, 1'b0));
        end
        bus.out_ready = 1'b1;
        seen.delete();
        if (bus.out_valid) seen.push_back(bus.out_operand1);
        for (int i = 0; i < 6; i++) begin
            accept_now = bus.in_valid && bus.in_ready;
            @(negedge clk);
            if (accept_now) bus.in_valid = 1'b0;
            if (bus.out_valid) seen.push_back(bus.out_operand1);
        end
        check("bp_count", W'(seen.size()), W'(3));
        for (int i = 0; i < 3; i++)
            check("bp_order", W'(i < seen.size() ? seen[i] : 32'hDEAD), W'(i + 1));

        // flush with both entries full and input pending
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_instr = add_instr(4); bus.in_rs1_data = 32'd4;
        @(negedge clk);
        bus.in_instr = add_instr(5); bus.in_rs1_data = 32'd5;
        @(negedge clk);
        check("fl_full", W'(bus.in_ready), W'(1'b0));
        flush = 1'b1;
        bus.in_instr = add_instr(6); bus.in_rs1_data = 32'd6;
        @(negedge clk);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        check("fl_valid", W'(bus.out_valid), W'(1'b0));
        check("fl_ready", W'(bus.in_ready), W'(1'b1));
        // flush with one entry and an input that would otherwise be accepted
        bus.in_valid = 1'b1;
        bus.in_instr = add_instr(7); bus.in_rs1_data = 32'd7;
        @(negedge clk);
        flush = 1'b1;
        bus.in_instr = add_instr(8); bus.in_rs1_data = 32'd8;
        @(negedge clk);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        check("fl1_valid", W'(bus.out_valid), W'(1'b0));
        repeat (3) begin
            @(negedge clk);
            check("fl_nothing_left", W'(bus.out_valid), W'(1'b0));
        end

        // illegal entry held, then asynchronous reset mid-cycle
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h4020D1B3; bus.in_rs1_data = 32'd5; bus.in_rs2_data = 32'd7;
        @(negedge clk);
        bus.in_instr = add_instr(9);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("ill_entry", get_act(), mk_exp(32'd0, 32'd0, A_ILL, 5'd3, 1'b1));
        check("ill_ready", W'(bus.in_ready), W'(1'b0));
        #2 rst = 1'b1;
        #1;
        check("arst_valid", W'(bus.out_valid), W'(1'b0));
        check("arst_ready", W'(bus.in_ready), W'(1'b1));
        check("arst_fields", get_act(), W'(0));
        @(negedge clk);
        rst = 1'b0;

        // random traffic against the FIFO model
        exp_q.delete();
        for (int cyc = 0; cyc < 800; cyc++) begin
            bit          v;
            bit          rdy;
            bit          fl;
            logic [31:0] ins;
            logic [31:0] r1;
            logic [31:0] r2;
            bit          acc;
            bit          drn;
            check("rnd_valid", W'(bus.out_valid), W'(exp_q.size() != 0));
            check("rnd_ready", W'(bus.in_ready), W'(exp_q.size() < 2));
            if (exp_q.size() != 0) check("rnd_data", get_act(), exp_q[0]);
            v   = ($urandom_range(0, 99) < 70);
            rdy = ($urandom_range(0, 99) < 55);
            fl  = ($urandom_range(0, 99) < 4);
            ins = gen_instr();
            r1  = $urandom;
            r2  = $urandom;
            if (fl) begin
                exp_q.delete();
            end else begin
                acc = v && (exp_q.size() < 2);
                drn = (exp_q.size() != 0) && rdy;
                if (drn) void'(exp_q.pop_front());
                if (acc) exp_q.push_back(ref_decode(ins, r1, r2));
            end
            bus.in_valid = v;
            bus.out_ready = rdy;
            flush = fl;
            bus.in_instr = ins;
            bus.in_rs1_data = r1;
            bus.in_rs2_data = r2;
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
